cpu_host_ctrl: RTL

Host-side controller that drives the processor's external memory-access ports and its `enable` input. It takes commands from a valid/ready stream: write instruction memory, write data memory, read either memory, or run the core for N cycles. It returns read data on a valid/ready response stream. It sits outside `cpu`, between the testbench/host link and the `addr_ext*`/`wen_ext*`/`ren_ext*`/`wdata_ext*`/`rdata_ext*`/`enable` pins.

---
 rtl/cpu_host_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cpu_host_ctrl.sv
// Host-side controller for the cpu external memory ports and run enable.
// Latency: write 1 cycle, read RD_LAT+1 cycles to rsp_valid, run N cycles, plus 1 return cycle.
// Backpressure: cmd_ready only in IDLE; the response is held in RSP until rsp_ready.
// Ports: cmd_* command stream in, rsp_* read response out, *_ext imem port,
//        *_ext_2 dmem port, enable to the core, busy/run_done/err status.
module cpu_host_ctrl #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] addr_ext,
  output logic [DATA_W-1:0] wdata_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic [DATA_W-1:0] addr_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              enable,
  output logic              busy,
  output logic              run_done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RSP, RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] cnt;   // read latency counter or remaining run cycles
  logic              sel;   // 1 = data memory port is the target of the current access

  // Both are pure decodes of the state register, so they change only on clock edges.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sel         <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      wen_ext     <= 1'b0;
      ren_ext     <= 1'b0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      enable      <= 1'b0;
      run_done    <= 1'b0;
      err         <= 1'b0;
    end else begin
      run_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                sel <= cmd_op[0];
                if (cmd_op[0]) begin
                  addr_ext_2  <= cmd_addr;
                  wdata_ext_2 <= cmd_data;
                  wen_ext_2   <= ~cmd_op[1];
                  ren_ext_2   <= cmd_op[1];
                end else begin
                  addr_ext  <= cmd_addr;
                  wdata_ext <= cmd_data;
                  wen_ext   <= ~cmd_op[1];
                  ren_ext   <= cmd_op[1];
                end
                cnt   <= DATA_W'(RD_LAT);
                state <= cmd_op[1] ? READ : WRITE;
              end
              3'b100: begin
                if (cmd_data == '0) begin
                  // Zero-length run: nothing to enable, report completion at once.
                  run_done <= 1'b1;
                end else begin
                  enable <= 1'b1;
                  cnt    <= cmd_data;
                  state  <= RUN;
                end
              end
              default: err <= 1'b1;
            endcase
          end
        end
        WRITE: begin
          wen_ext   <= 1'b0;
          wen_ext_2 <= 1'b0;
          state     <= IDLE;
        end
        READ: begin
          // Strobe is held RD_LAT cycles; one extra cycle lets the sram output settle
          // before it is captured.
          if (cnt == '0) begin
            rsp_data  <= sel ? rdata_ext_2 : rdata_ext;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else begin
            cnt <= cnt - DATA_W'(1);
            if (cnt == DATA_W'(1)) begin
              ren_ext   <= 1'b0;
              ren_ext_2 <= 1'b0;
            end
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        RUN: begin
          if (cnt == DATA_W'(1)) begin
            enable   <= 1'b0;
            run_done <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - DATA_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
